sm_control_param: RTL and testbench
===================================

SM_CONTROL_PARAM -- requirements
Module: sm_control_param

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, the multiplier operand width in bits (legal range 1..32).
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begins a multiplication; sampled only in IDLE.
REQ-005 mr  input  WIDTH  multiplier register contents from the datapath.
REQ-006 mdld  output  1  load the multiplicand register.
REQ-007 mrld  output  1  load the multiplier register.
REQ-008 rsclear  output  1  clear the running-sum register.
REQ-009 rsload  output  1  load the running sum with sum plus multiplicand.
REQ-010 rsshr  output  1  shift the running-sum register right by one.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have the states IDLE, INIT, TEST, ADD, SHIFT and DONE; all outputs are Moore outputs decoded from the state only.
REQ-014 IDLE SHALL go to INIT when start=1 and stay in IDLE otherwise; it asserts no outputs.
REQ-015 INIT SHALL assert mdld, mrld and rsclear, clear the bit counter to 0, and go to TEST unconditionally.
REQ-016 TEST SHALL assert no outputs; it goes to ADD if mr[0]=1 and to SHIFT otherwise.
REQ-017 ADD SHALL assert rsload and go to SHIFT.
REQ-018 SHIFT SHALL assert rsshr and take one of two paths.
- If cnt == WIDTH-1: go to DONE.
- Otherwise: increment cnt, then go to ADD if mr[cnt+1]=1 and to SHIFT otherwise (cnt+1 is the post-increment index).
REQ-019 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-020 The bit counter SHALL be max(1,$clog2(WIDTH)) bits wide, SHALL never exceed WIDTH-1, and SHALL hold its value in every state except INIT and SHIFT.
REQ-021 Latency, with start sampled at edge k:
- INIT occupies cycle k+1 and TEST occupies cycle k+2.
- done is high in cycle k+3+WIDTH+popcount(mr).
REQ-022 A start arriving while busy=1 SHALL be ignored, with no queuing.
REQ-023 A start held high through DONE SHALL begin a new operation from IDLE on the following edge.
REQ-024 The datapath SHALL keep mr stable from the end of INIT until done; the block does not latch mr.

Reset
REQ-025 Asserting rst SHALL immediately force the state to IDLE and cnt to 0, independent of clk.
REQ-026 While rst is high, mdld, mrld, rsclear, rsload, rsshr, busy and done SHALL all be 0.
REQ-027 Reset asserted mid-operation SHALL abandon the operation without a done pulse; the first start after rst deasserts SHALL begin a fresh operation.

Configuration
REQ-028 The macro SM_MERGE_ADDSHR_EN SHALL select the ADD-state behaviour.
- Defined: ADD asserts rsload and rsshr together (the datapath adds then shifts in one cycle) and takes the SHIFT transitions of REQ-018, including the counter update. Done then falls in cycle k+3+WIDTH.
- Undefined: behaviour is exactly REQ-017.

Structure
REQ-029 The state encoding constants, the reset state value and the counter-width function SHALL reside in the shared sm package/header used by the multiplier family.
REQ-030 The bit counter SHALL be a sub-module, sm_bit_counter, with clear, increment and terminal-count (cnt == WIDTH-1) outputs.

Verification
REQ-031 The bench SHALL cover these directed scenarios.
- WIDTH=4, mr=4'b1011, start at edge k, macro off: rsload high 3 cycles, rsshr high 4 cycles, done in cycle k+10 only.
- WIDTH=4, mr=4'b0000, macro off: rsload never asserted, rsshr 4 cycles, done in cycle k+7.
- WIDTH=4, mr=4'b1011, macro on: rsload high 3 cycles, each coincident with rsshr; rsshr 4 cycles; done in cycle k+7.
- WIDTH=8, mr=8'hFF, macro off: done in cycle k+19; busy high continuously from k+1 to k+19.
- WIDTH=4, start re-pulsed while busy: ignored. Then rst pulsed mid-SHIFT asynchronously: all outputs drop to 0 before the next clk edge, no done pulse occurs, and the next start completes normally.

Source files
------------

// File: rtl/sm_pkg.sv
// Shared package for the shift-add multiplier family: state encoding, reset
// state and the bit-counter width helper.
package sm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    TEST  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } sm_state_t;

  localparam sm_state_t SM_RESET_STATE = IDLE;

  // A one-bit operand still needs a one-bit counter.
  function automatic int sm_cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/sm_bit_counter.sv
// Multiplier bit index counter: synchronous clear, saturating increment,
// terminal count when the last operand bit is reached.
module sm_bit_counter
  import sm_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int CW = sm_cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !tc) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sm_control_param.sv
// Shift-add multiplier controller (Moore FSM). Define SM_MERGE_ADDSHR_EN to
// have ADD load and shift the running sum in the same cycle.
module sm_control_param
  import sm_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] mr,
  output logic             mdld,
  output logic             mrld,
  output logic             rsclear,
  output logic             rsload,
  output logic             rsshr,
  output logic             busy,
  output logic             done,
  output sm_state_t        dbg_state
);

  localparam int CW = sm_cnt_width(WIDTH);

  sm_state_t       state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            cnt_tc, cnt_clr, cnt_inc;
  logic            shift_step;
  logic            next_bit;

  sm_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .cnt (cnt),
    .tc  (cnt_tc)
  );

  assign dbg_state = state;

  // Multiplier bit the counter will point at after this increment.
  always_comb begin
    next_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i == int'(cnt) + 1) next_bit = mr[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SM_RESET_STATE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mdld       = 1'b0;
    mrld       = 1'b0;
    rsclear    = 1'b0;
    rsload     = 1'b0;
    rsshr      = 1'b0;
    done       = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    shift_step = 1'b0;
    busy       = (state != IDLE);

    case (state)
      IDLE:  if (start) state_nxt = INIT;
      INIT: begin
        mdld      = 1'b1;
        mrld      = 1'b1;
        rsclear   = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = TEST;
      end
      TEST:  state_nxt = mr[0] ? ADD : SHIFT;
      ADD: begin
        rsload = 1'b1;
`ifdef SM_MERGE_ADDSHR_EN
        rsshr      = 1'b1;
        shift_step = 1'b1;
`else
        state_nxt  = SHIFT;
`endif
      end
      SHIFT: begin
        rsshr      = 1'b1;
        shift_step = 1'b1;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = SM_RESET_STATE;
    endcase

    // Every shift consumes one multiplier bit; the last one ends the operation.
    if (shift_step) begin
      if (cnt_tc) begin
        state_nxt = DONE;
      end else begin
        cnt_inc   = 1'b1;
        state_nxt = next_bit ? ADD : SHIFT;
      end
    end
  end

endmodule

// File: tb/tb_sm_control_param.sv
// Directed bench for sm_control_param: WIDTH=4 and WIDTH=8 instances, latency,
// output-pulse counts, busy-start handling and asynchronous reset.
module tb_sm_control_param;
  import sm_pkg::*;

`ifdef SM_MERGE_ADDSHR_EN
  localparam bit MERGED = 1'b1;
`else
  localparam bit MERGED = 1'b0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start4 = 1'b0, start8 = 1'b0;
  logic [3:0] mr4 = '0;
  logic [7:0] mr8 = '0;

  logic mdld4, mrld4, rsclear4, rsload4, rsshr4, busy4, done4;
  logic mdld8, mrld8, rsclear8, rsload8, rsshr8, busy8, done8;
  sm_state_t state4, state8;

  // Packed view: {mdld, mrld, rsclear, rsload, rsshr, busy, done}
  logic [6:0] o4, o8;
  assign o4 = {mdld4, mrld4, rsclear4, rsload4, rsshr4, busy4, done4};
  assign o8 = {mdld8, mrld8, rsclear8, rsload8, rsshr8, busy8, done8};

  sm_control_param #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .mr(mr4),
    .mdld(mdld4), .mrld(mrld4), .rsclear(rsclear4), .rsload(rsload4),
    .rsshr(rsshr4), .busy(busy4), .done(done4), .dbg_state(state4)
  );

  sm_control_param #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .mr(mr8),
    .mdld(mdld8), .mrld(mrld8), .rsclear(rsclear8), .rsload(rsload8),
    .rsshr(rsshr8), .busy(busy8), .done(done8), .dbg_state(state8)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total_cnt++;
    if (o4 !== 7'b0) $display("FAIL reset_outputs_w4: got %b expected %b", o4, 7'b0);
    else pass_cnt++;
    total_cnt++;
    if (o8 !== 7'b0) $display("FAIL reset_outputs_w8: got %b expected %b", o8, 7'b0);
    else pass_cnt++;
    total_cnt++;
    if (state4 !== IDLE) $display("FAIL reset_state_w4: got %0d expected %0d", state4, IDLE);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (o4 !== 7'b0) $display("FAIL idle_after_reset_w4: got %b expected %b", o4, 7'b0);
    else pass_cnt++;
  endtask

  // One full operation; cycle j is the period following the j-th edge after start.
  task automatic run_op(input bit w8, input logic [7:0] mrv, input int repulse,
                        input string name);
    int w, pop, exp_done, exp_both;
    int ld, shr, both, dn, first_done, busy_err;
    logic [6:0] o, init_o;
    w        = w8 ? 8 : 4;
    pop      = w8 ? $countones(mrv) : $countones(mrv[3:0]);
    exp_done = 3 + w + (MERGED ? 0 : pop);
    exp_both = MERGED ? pop : 0;
    ld = 0; shr = 0; both = 0; dn = 0; first_done = 0; busy_err = 0;
    init_o = '0;

    @(negedge clk);
    if (w8) begin start8 = 1'b1; mr8 = mrv; end
    else    begin start4 = 1'b1; mr4 = mrv[3:0]; end

    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      o = w8 ? o8 : o4;
      if (j == 1) init_o = o;
      ld   += int'(o[3]);
      shr  += int'(o[2]);
      both += int'(o[3] & o[2]);
      if (o[0]) begin
        dn++;
        if (first_done == 0) first_done = j;
      end
      if (o[1] !== (j <= exp_done)) busy_err++;
      if (j == 1 || j == repulse + 1) begin start4 = 1'b0; start8 = 1'b0; end
      if (repulse > 0 && j == repulse) begin
        if (w8) start8 = 1'b1;
        else    start4 = 1'b1;
      end
    end

    total_cnt++;
    if (init_o !== 7'b1110010) $display("FAIL %s_init_outputs: got %b expected %b", name, init_o, 7'b1110010);
    else pass_cnt++;
    total_cnt++;
    if (first_done !== exp_done) $display("FAIL %s_done_cycle: got %0d expected %0d", name, first_done, exp_done);
    else pass_cnt++;
    total_cnt++;
    if (dn !== 1) $display("FAIL %s_done_pulses: got %0d expected %0d", name, dn, 1);
    else pass_cnt++;
    total_cnt++;
    if (ld !== pop) $display("FAIL %s_rsload_cycles: got %0d expected %0d", name, ld, pop);
    else pass_cnt++;
    total_cnt++;
    if (shr !== w) $display("FAIL %s_rsshr_cycles: got %0d expected %0d", name, shr, w);
    else pass_cnt++;
    total_cnt++;
    if (both !== exp_both) $display("FAIL %s_load_shift_overlap: got %0d expected %0d", name, both, exp_both);
    else pass_cnt++;
    total_cnt++;
    if (busy_err !== 0) $display("FAIL %s_busy_window: got %0d bad cycles expected %0d", name, busy_err, 0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start4 = 1'b1;
    mr4    = 4'b0000;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      if (j == 7) begin
        total_cnt++;
        if (done4 !== 1'b1) $display("FAIL b2b_done: got %b expected %b", done4, 1'b1);
        else pass_cnt++;
      end
      if (j == 8) begin
        total_cnt++;
        if (busy4 !== 1'b0) $display("FAIL b2b_idle_gap: got %b expected %b", busy4, 1'b0);
        else pass_cnt++;
      end
      if (j == 9) begin
        total_cnt++;
        if (mdld4 !== 1'b1) $display("FAIL b2b_restart_init: got %b expected %b", mdld4, 1'b1);
        else pass_cnt++;
        start4 = 1'b0;
      end
    end
    repeat (12) @(negedge clk);
    total_cnt++;
    if (busy4 !== 1'b0) $display("FAIL b2b_second_op_end: got %b expected %b", busy4, 1'b0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    int dn;
    dn = 0;
    @(negedge clk);
    start4 = 1'b1;
    mr4    = 4'b0000;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      if (j == 1) start4 = 1'b0;
    end
    total_cnt++;
    if (rsshr4 !== 1'b1) $display("FAIL midrst_in_shift: got %b expected %b", rsshr4, 1'b1);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (o4 !== 7'b0) $display("FAIL midrst_async_outputs: got %b expected %b", o4, 7'b0);
    else pass_cnt++;
    total_cnt++;
    if (state4 !== IDLE) $display("FAIL midrst_async_state: got %0d expected %0d", state4, IDLE);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (o4 !== 7'b0) $display("FAIL midrst_held_outputs: got %b expected %b", o4, 7'b0);
    else pass_cnt++;
    rst = 1'b0;
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      dn += int'(done4);
    end
    total_cnt++;
    if (dn !== 0) $display("FAIL midrst_no_done: got %0d expected %0d", dn, 0);
    else pass_cnt++;
    run_op(1'b0, 8'h0B, 0, "w4_after_rst");
  endtask

  initial begin
    test_reset();
    run_op(1'b0, 8'h0B, 0, "w4_1011");
    run_op(1'b0, 8'h00, 0, "w4_0000");
    run_op(1'b1, 8'hFF, 0, "w8_ff");
    run_op(1'b1, 8'h5A, 0, "w8_5a");
    run_op(1'b0, 8'h0B, 3, "w4_repulse");
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
